// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with registered read data, status flags and sticky error flags
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int AF_THRESH  = 120,
  parameter int AE_THRESH  = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // Status flags come straight from the registered count so reset forces them immediately
  always_comb begin
    full         = count_q == FULL_CNT;
    empty        = count_q == '0;
    almost_full  = count_q >= AF_CNT;
    almost_empty = count_q <= AE_CNT;
    count        = count_q;
    data_out     = data_out_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Accept logic and next-state: a write into a full FIFO is allowed when a read frees a slot the same edge
  always_comb begin
    rd_acc      = r_en && !empty && !clear;
    wr_acc      = w_en && (!full || rd_acc) && !clear;
    wr_ptr_d    = clear ? '0 : wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = clear ? '0 : rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = clear ? '0 : (wr_acc && !rd_acc) ? count_q + CW'(1) :
                  (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
    data_out_d  = rd_acc ? mem[rd_ptr_q] : data_out_q;
    overflow_d  = !clear && (overflow_q || (w_en && !wr_acc));
    underflow_d = !clear && (underflow_q || (r_en && !rd_acc));
  end

  // Control state with asynchronous reset; queued data is discarded by zeroing pointers and count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is never reset or cleared
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo at DEPTH=8
module tb_param_fifo;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  int         total = 0;
  int         passed = 0;
  int         fails = 0;

  param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    w_en = w;
    r_en = r;
    clear = c;
    data_in = d;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
    chk({tag, "_dout"}, 32'(data_out), 0);
  endtask

  initial begin
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0, 8'(k * 8'h11));
      chk("fill_count", 32'(count), 32'(k));
      chk("fill_af", 32'(almost_full), 32'(k >= 6));
      chk("fill_ae", 32'(almost_empty), 32'(k <= 2));
      chk("fill_full", 32'(full), 32'(k == 8));
    end
    step(1, 0, 0, 8'h99);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0, 8'h00);
      chk("drain_dout", 32'(data_out), 32'(k * 8'h11));
      chk("drain_count", 32'(count), 32'(8 - k));
    end
    chk("drain_empty", 32'(empty), 1);
    step(0, 1, 0, 8'h00);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dout_hold", 32'(data_out), 32'h88);
    chk("udf_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    step(0, 0, 1, 8'h00);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 8'(8'h20 + i));
      chk("alt_wcount", 32'(count), 1);
      step(0, 1, 0, 8'h00);
      chk("alt_dout", 32'(data_out), 32'(8'h20 + i));
      chk("alt_rcount", 32'(count), 0);
    end
    chk("alt_udf", 32'(underflow), 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'hA0 + i));
    chk("full2", 32'(full), 1);
    step(1, 1, 0, 8'hAB);
    chk("fullrw_dout", 32'(data_out), 32'hA0);
    chk("fullrw_count", 32'(count), 8);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 8'h00);
      chk("fullrw_drain", 32'(data_out), (i == 8) ? 32'hAB : 32'(8'hA0 + i));
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h50 + i));
    chk("pre_clr_count", 32'(count), 5);
    step(1, 0, 1, 8'hEE);
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr2_ovf", 32'(overflow), 0);
    chk("clr2_udf", 32'(underflow), 0);
    chk("clr_dout_kept", 32'(data_out), 32'hAB);
    step(0, 1, 0, 8'h00);
    chk("clr_nowrite_udf", 32'(underflow), 1);
    chk("clr_nowrite_dout", 32'(data_out), 32'hAB);
    step(1, 1, 0, 8'h5A);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_dout", 32'(data_out), 32'hAB);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hC0 + i));
    chk("pre_rst_count", 32'(count), 4);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    step(0, 1, 0, 8'h00);
    chk("post_rst_udf", 32'(underflow), 1);
    chk("post_rst_dout", 32'(data_out), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter AF_THRESH, default 120, count at or above which almost_full asserts; 1..DEPTH-1.
REQ-004 SHALL have parameter AE_THRESH, default 8, count at or below which almost_empty asserts; 1..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port clear  input  1  synchronous flush of all contents and flags.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port r_en  input  1  read request.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a read when r_en=1 and empty=0; rejected reads change no state except underflow.
REQ-016 SHALL accept a write when w_en=1 and (full=0 or a read is accepted the same cycle).
REQ-017 SHALL store an accepted write at the write pointer; write pointer then increments, wrapping DEPTH-1 -> 0.
REQ-018 SHALL, on an accepted read, load data_out with the entry at the read pointer on that clock edge (1-cycle latency); read pointer then increments, wrapping DEPTH-1 -> 0.
REQ-019 SHALL hold data_out unchanged in cycles with no accepted read.
REQ-020 SHALL update count each edge: +1 write only, -1 read only, unchanged both or neither; count never exceeds DEPTH or drops below 0.
REQ-021 SHALL derive flags from registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-022 SHALL, when empty and w_en=r_en=1, reject the read and accept the write (count 0 -> 1, data_out unchanged, underflow set).
REQ-023 SHALL, when full and w_en=r_en=1, accept both; count stays DEPTH; overflow not set.
REQ-024 SHALL set overflow when w_en=1 and the write is rejected; held until clear or reset.
REQ-025 SHALL set underflow when r_en=1 and empty=0 is false; held until clear or reset.
REQ-026 SHALL, when clear=1, zero both pointers, count, overflow, underflow on that edge, ignoring w_en/r_en in that cycle; data_out and memory contents retained.
REQ-027 SHALL not reset or clear storage array contents.

Reset
REQ-028 SHALL, while n_rst=0, force immediately: count=0, pointers=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after n_rst deasserts; reset mid-transfer discards all queued data.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-030 SHALL verify: write 0x11..0x88 (8 writes) -> count=8, full=1, almost_full=1 from count 6; 9th write 0x99 -> overflow=1, count stays 8.
REQ-031 SHALL verify: then 8 reads -> data_out 0x11..0x88 in order, each one cycle after its read; 9th read -> underflow=1, data_out stays 0x88, empty=1.
REQ-032 SHALL verify: 20 alternating write/read pairs over wrap boundary -> data order preserved, pointers wrap, count never >1.
REQ-033 SHALL verify: full, w_en=r_en=1 with data_in 0xAB -> oldest word out, count=8, overflow=0; 0xAB read out last of next 8.
REQ-034 SHALL verify: count=5, clear=1 with w_en=1 -> next cycle count=0, empty=1, overflow=underflow=0, no write taken.
REQ-035 SHALL verify: n_rst pulsed low mid-cycle at count=4 -> outputs reach reset values without clock edge; post-reset read -> underflow=1.
